// File: rtl/hazard_ctrl_if.sv
// ----------------------------------------------------------------------------
// hazard_ctrl_if
//   Bundles the pipeline-side signals seen and driven by the hazard controller.
//   master : the pipeline datapath (drives register IDs / instr attributes,
//            consumes stall, flush, forward and divider controls)
//   slave  : hazard_ctrl itself
//   Signals:
//     D stage : rsD, rtD, branchD
//     E stage : rsE, rtE, writeregE, regwriteE, memtoregE, divE, pred_missE
//     M stage : writeregM, regwriteM, memtoregM
//     W stage : writeregW, regwriteW
//     controls: stallF/D/E, flushD/E/M, forwardaD/bD, forwardaE/bE,
//               div_start, div_busy
// ----------------------------------------------------------------------------
interface hazard_ctrl_if;
    logic [4:0] rsD;
    logic [4:0] rtD;
    logic       branchD;
    logic [4:0] rsE;
    logic [4:0] rtE;
    logic [4:0] writeregE;
    logic       regwriteE;
    logic [1:0] memtoregE;
    logic       divE;
    logic       pred_missE;
    logic [4:0] writeregM;
    logic       regwriteM;
    logic [1:0] memtoregM;
    logic [4:0] writeregW;
    logic       regwriteW;

    logic       stallF;
    logic       stallD;
    logic       stallE;
    logic       flushD;
    logic       flushE;
    logic       flushM;
    logic       forwardaD;
    logic       forwardbD;
    logic [1:0] forwardaE;
    logic [1:0] forwardbE;
    logic       div_start;
    logic       div_busy;

    modport master (
        output rsD, rtD, branchD, rsE, rtE, writeregE, regwriteE, memtoregE,
               divE, pred_missE, writeregM, regwriteM, memtoregM,
               writeregW, regwriteW,
        input  stallF, stallD, stallE, flushD, flushE, flushM,
               forwardaD, forwardbD, forwardaE, forwardbE, div_start, div_busy
    );

    modport slave (
        input  rsD, rtD, branchD, rsE, rtE, writeregE, regwriteE, memtoregE,
               divE, pred_missE, writeregM, regwriteM, memtoregM,
               writeregW, regwriteW,
        output stallF, stallD, stallE, flushD, flushE, flushM,
               forwardaD, forwardbD, forwardaE, forwardbE, div_start, div_busy
    );
endinterface

// File: rtl/hazard_ctrl.sv
// ----------------------------------------------------------------------------
// hazard_ctrl
//   Hazard and sequencing controller for the 5-stage MIPS pipeline:
//   operand forwarding for the D and E stages, load-use and branch-operand
//   stalls, mispredict flushes, and the multi-cycle divider sequencer.
//   Ports:
//     clk  - clock
//     rst  - synchronous reset, active-high
//     hz   - hazard_ctrl_if.slave bundle (pipeline inputs, control outputs)
//   Parameters:
//     DIV_CYCLES - divider latency after div_start (2..64)
//     CW         - counter width, 2**CW > DIV_CYCLES
// ----------------------------------------------------------------------------
module hazard_ctrl #(
    parameter int DIV_CYCLES = 32,
    parameter int CW         = 6
) (
    input  logic         clk,
    input  logic         rst,
    hazard_ctrl_if.slave hz
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_BUSY = 2'd1,
        S_DONE = 2'd2
    } state_t;

    // The start cycle and the final BUSY cycle (cnt==0) are both stall
    // cycles, so loading DIV_CYCLES-2 gives DIV_CYCLES stall cycles in total.
    localparam logic [CW-1:0] CNT_LOAD = CW'(DIV_CYCLES - 2);

    // Register 0 is hard-wired to zero and never creates a dependency.
    function automatic logic reg_hit(input logic [4:0] a, input logic [4:0] b);
        return (a != 5'd0) && (a == b);
    endfunction

    state_t        state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;

    logic          div_start_c;
    logic          div_busy_c;
    logic          lwstall;
    logic          brstall;

    // ------------------------------------------------------------------
    // Forwarding: index 0 = operand a (rs), index 1 = operand b (rt)
    // ------------------------------------------------------------------
    logic [4:0] src_d [2];
    logic [4:0] src_e [2];
    logic       fwd_d [2];
    logic [1:0] fwd_e [2];
    logic       src_d_hit_e [2];
    logic       src_d_hit_m [2];

    assign src_d[0] = hz.rsD;
    assign src_d[1] = hz.rtD;
    assign src_e[0] = hz.rsE;
    assign src_e[1] = hz.rtE;

    genvar gi;
    generate
        for (gi = 0; gi < 2; gi++) begin : g_operand
            // The M-stage result is newer than W, so it wins when both match.
            assign fwd_e[gi] = (hz.regwriteM && reg_hit(hz.writeregM, src_e[gi])) ? 2'b10 :
                               (hz.regwriteW && reg_hit(hz.writeregW, src_e[gi])) ? 2'b01 :
                                                                                    2'b00;
            assign fwd_d[gi]       = hz.regwriteM && reg_hit(hz.writeregM, src_d[gi]);
            assign src_d_hit_e[gi] = reg_hit(hz.writeregE, src_d[gi]);
            assign src_d_hit_m[gi] = reg_hit(hz.writeregM, src_d[gi]);
        end
    endgenerate

    assign hz.forwardaE = fwd_e[0];
    assign hz.forwardbE = fwd_e[1];
    assign hz.forwardaD = fwd_d[0];
    assign hz.forwardbD = fwd_d[1];

    // ------------------------------------------------------------------
    // Data hazards
    // ------------------------------------------------------------------
    assign lwstall = (hz.memtoregE != 2'b00) && (src_d_hit_e[0] || src_d_hit_e[1]);

    // A D-stage branch compares operands early: an E-stage result is not
    // ready yet, and a load in M only has its data at the end of M.
    assign brstall = hz.branchD &&
                     ((hz.regwriteE && (src_d_hit_e[0] || src_d_hit_e[1])) ||
                      ((hz.memtoregM != 2'b00) && (src_d_hit_m[0] || src_d_hit_m[1])));

    // ------------------------------------------------------------------
    // Divider sequencer
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        div_start_c = 1'b0;
        div_busy_c  = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (hz.divE) begin
                    div_start_c = 1'b1;
                    state_d     = S_BUSY;
                    cnt_d       = CNT_LOAD;
                end
            end
            S_BUSY: begin
                div_busy_c = 1'b1;
                if (cnt_q == '0) begin
                    state_d = S_DONE;
                end else begin
                    cnt_d = cnt_q - CW'(1);
                end
            end
            S_DONE: begin
                // The dividing instr leaves E this cycle; its divE is stale.
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
                cnt_d   = '0;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Stall / flush priority
    // ------------------------------------------------------------------
    always_comb begin
        hz.stallF    = 1'b0;
        hz.stallD    = 1'b0;
        hz.stallE    = 1'b0;
        hz.flushD    = 1'b0;
        hz.flushE    = 1'b0;
        hz.flushM    = 1'b0;
        hz.div_start = 1'b0;
        hz.div_busy  = 1'b0;
        if (rst) begin
            // keep everything quiet while the pipeline is being reset
        end else if (div_start_c || div_busy_c) begin
            // The whole front end freezes behind the divide; the
            // mispredict (if any) is acted on once E is allowed to move.
            hz.stallF    = 1'b1;
            hz.stallD    = 1'b1;
            hz.stallE    = 1'b1;
            hz.flushM    = div_busy_c;
            hz.div_start = div_start_c;
            hz.div_busy  = div_busy_c;
        end else if (hz.pred_missE) begin
            // D holds a wrong-path instr, so any stall it causes is moot.
            hz.flushD = 1'b1;
            hz.flushE = 1'b1;
        end else if (lwstall || brstall) begin
            hz.stallF = 1'b1;
            hz.stallD = 1'b1;
            hz.flushE = 1'b1;
        end
    end

endmodule

// File: tb/tb_hazard_ctrl.sv
module tb_hazard_ctrl;

    localparam int N = 32;

    typedef struct packed {
        logic [4:0] rsD;
        logic [4:0] rtD;
        logic       branchD;
        logic [4:0] rsE;
        logic [4:0] rtE;
        logic [4:0] writeregE;
        logic       regwriteE;
        logic [1:0] memtoregE;
        logic       divE;
        logic       pred_missE;
        logic [4:0] writeregM;
        logic       regwriteM;
        logic [1:0] memtoregM;
        logic [4:0] writeregW;
        logic       regwriteW;
    } in_t;

    typedef struct {
        string       name;
        in_t         i;
        logic [13:0] e;
    } vec_t;

    logic clk;
    logic rst;
    hazard_ctrl_if hif();

    hazard_ctrl #(.DIV_CYCLES(N), .CW(6)) dut (
        .clk (clk),
        .rst (rst),
        .hz  (hif.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int   checks   = 0;
    int   failures = 0;
    int   age      = -1;   // -1 idle, 1..N-1 busy, N done
    in_t  cur;
    vec_t vecs [13];

    // Output bundle: {stallF,stallD,stallE,flushD,flushE,flushM,
    //                 forwardaD,forwardbD,forwardaE,forwardbE,div_start,div_busy}
    function automatic logic [13:0] exp_o(input logic sf, input logic sd, input logic se,
                                          input logic fd, input logic fe, input logic fm,
                                          input logic fad, input logic fbd,
                                          input logic [1:0] fae, input logic [1:0] fbe,
                                          input logic ds, input logic db);
        return {sf, sd, se, fd, fe, fm, fad, fbd, fae, fbe, ds, db};
    endfunction

    function automatic logic [13:0] dut_out();
        return {hif.stallF, hif.stallD, hif.stallE, hif.flushD, hif.flushE, hif.flushM,
                hif.forwardaD, hif.forwardbD, hif.forwardaE, hif.forwardbE,
                hif.div_start, hif.div_busy};
    endfunction

    function automatic logic hit(input logic [4:0] a, input logic [4:0] b);
        return (a != 5'd0) && (a == b);
    endfunction

    // Reference model straight from the rules; the divider is tracked as
    // "cycles since the start cycle" rather than a down-counter.
    function automatic logic [13:0] model(input in_t x, input int a, input logic r);
        logic [1:0] fae, fbe;
        logic fad, fbd, lw, br, ds, db;
        fae = (x.regwriteM && hit(x.writeregM, x.rsE)) ? 2'd2 :
              (x.regwriteW && hit(x.writeregW, x.rsE)) ? 2'd1 : 2'd0;
        fbe = (x.regwriteM && hit(x.writeregM, x.rtE)) ? 2'd2 :
              (x.regwriteW && hit(x.writeregW, x.rtE)) ? 2'd1 : 2'd0;
        fad = x.regwriteM && hit(x.writeregM, x.rsD);
        fbd = x.regwriteM && hit(x.writeregM, x.rtD);
        lw  = (x.memtoregE != 0) && (hit(x.writeregE, x.rsD) || hit(x.writeregE, x.rtD));
        br  = x.branchD &&
              ((x.regwriteE && (hit(x.writeregE, x.rsD) || hit(x.writeregE, x.rtD))) ||
               ((x.memtoregM != 0) && (hit(x.writeregM, x.rsD) || hit(x.writeregM, x.rtD))));
        if (r) return exp_o(0, 0, 0, 0, 0, 0, fad, fbd, fae, fbe, 0, 0);
        ds = (a < 0) && x.divE;
        db = (a >= 1) && (a <= N - 1);
        if (ds || db)     return exp_o(1, 1, 1, 0, 0, db, fad, fbd, fae, fbe, ds, db);
        if (x.pred_missE) return exp_o(0, 0, 0, 1, 1, 0, fad, fbd, fae, fbe, 0, 0);
        if (lw || br)     return exp_o(1, 1, 0, 0, 1, 0, fad, fbd, fae, fbe, 0, 0);
        return exp_o(0, 0, 0, 0, 0, 0, fad, fbd, fae, fbe, 0, 0);
    endfunction

    task automatic apply(input in_t x);
        cur            = x;
        hif.rsD        = x.rsD;
        hif.rtD        = x.rtD;
        hif.branchD    = x.branchD;
        hif.rsE        = x.rsE;
        hif.rtE        = x.rtE;
        hif.writeregE  = x.writeregE;
        hif.regwriteE  = x.regwriteE;
        hif.memtoregE  = x.memtoregE;
        hif.divE       = x.divE;
        hif.pred_missE = x.pred_missE;
        hif.writeregM  = x.writeregM;
        hif.regwriteM  = x.regwriteM;
        hif.memtoregM  = x.memtoregM;
        hif.writeregW  = x.writeregW;
        hif.regwriteW  = x.regwriteW;
    endtask

    task automatic chk(input string nm, input logic [13:0] got, input logic [13:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%b exp=%b", nm, got, exp);
        end
    endtask

    task automatic chk_int(input string nm, input int got, input int exp);
        checks++;
        if (got != exp) begin
            failures++;
            $display("FAIL %s got=%0d exp=%0d", nm, got, exp);
        end
    endtask

    // Let combinational outputs settle; called 1 time unit after posedge.
    task automatic settle();
        #2;
    endtask

    // Advance the model with the current inputs, then cross the clock edge.
    task automatic advance();
        if (rst)                           age = -1;
        else if (age < 0)                  age = cur.divE ? 1 : -1;
        else if (age == N)                 age = -1;
        else                               age = age + 1;
        @(posedge clk);
        #1;
    endtask

    function automatic in_t rand_in();
        in_t x;
        x.rsD        = 5'($urandom_range(0, 3));
        x.rtD        = 5'($urandom_range(0, 3));
        x.branchD    = 1'($urandom_range(0, 1));
        x.rsE        = 5'($urandom_range(0, 3));
        x.rtE        = 5'($urandom_range(0, 3));
        x.writeregE  = 5'($urandom_range(0, 3));
        x.regwriteE  = 1'($urandom_range(0, 1));
        x.memtoregE  = 2'($urandom_range(0, 3));
        x.divE       = ($urandom_range(0, 19) == 0);
        x.pred_missE = ($urandom_range(0, 4) == 0);
        x.writeregM  = 5'($urandom_range(0, 3));
        x.regwriteM  = 1'($urandom_range(0, 1));
        x.memtoregM  = 2'($urandom_range(0, 3));
        x.writeregW  = 5'($urandom_range(0, 3));
        x.regwriteW  = 1'($urandom_range(0, 1));
        return x;
    endfunction

    initial begin
        in_t z;
        in_t x;
        int  n_start, n_busy, n_stallE;
        logic [13:0] e;

        z = '0;

        // ---------------- vector table (all in idle FSM state) ----------------
        x = z; x.regwriteM = 1; x.writeregM = 8; x.rsE = 8; x.regwriteW = 1; x.writeregW = 8;
        vecs[0] = '{"fwdaE_M", x, exp_o(0,0,0,0,0,0,0,0,2'd2,2'd0,0,0)};
        x = z; x.regwriteM = 0; x.writeregM = 8; x.rsE = 8; x.regwriteW = 1; x.writeregW = 8;
        vecs[1] = '{"fwdaE_W", x, exp_o(0,0,0,0,0,0,0,0,2'd1,2'd0,0,0)};
        x = z; x.regwriteM = 1; x.writeregM = 0; x.rsE = 0; x.regwriteW = 1; x.writeregW = 0;
        vecs[2] = '{"fwdaE_r0", x, exp_o(0,0,0,0,0,0,0,0,2'd0,2'd0,0,0)};
        x = z; x.regwriteM = 1; x.writeregM = 12; x.rtE = 12;
        vecs[3] = '{"fwdbE_M", x, exp_o(0,0,0,0,0,0,0,0,2'd0,2'd2,0,0)};
        x = z; x.regwriteM = 1; x.writeregM = 5; x.rsD = 5; x.rtD = 5;
        vecs[4] = '{"fwdD_ab", x, exp_o(0,0,0,0,0,0,1,1,2'd0,2'd0,0,0)};
        x = z; x.memtoregE = 1; x.regwriteE = 1; x.writeregE = 9; x.rtD = 9;
        vecs[5] = '{"lwstall_rt", x, exp_o(1,1,0,0,1,0,0,0,2'd0,2'd0,0,0)};
        x = z; x.memtoregE = 1; x.regwriteE = 1; x.writeregE = 0; x.rsD = 0;
        vecs[6] = '{"lw_r0", x, exp_o(0,0,0,0,0,0,0,0,2'd0,2'd0,0,0)};
        x = z; x.branchD = 1; x.rsD = 5; x.memtoregM = 1; x.writeregM = 5;
        vecs[7] = '{"brstall_M", x, exp_o(1,1,0,0,1,0,0,0,2'd0,2'd0,0,0)};
        x = z; x.branchD = 1; x.rtD = 7; x.regwriteE = 1; x.writeregE = 7;
        vecs[8] = '{"brstall_E", x, exp_o(1,1,0,0,1,0,0,0,2'd0,2'd0,0,0)};
        x = z; x.branchD = 0; x.rtD = 7; x.regwriteE = 1; x.writeregE = 7;
        vecs[9] = '{"nobranch_E", x, exp_o(0,0,0,0,0,0,0,0,2'd0,2'd0,0,0)};
        x = z; x.pred_missE = 1; x.memtoregE = 1; x.writeregE = 9; x.rtD = 9;
        vecs[10] = '{"miss_over_lw", x, exp_o(0,0,0,1,1,0,0,0,2'd0,2'd0,0,0)};
        x = z; x.pred_missE = 1;
        vecs[11] = '{"miss_only", x, exp_o(0,0,0,1,1,0,0,0,2'd0,2'd0,0,0)};
        x = z; x.regwriteM = 1; x.writeregM = 3; x.regwriteW = 1; x.writeregW = 4; x.rsE = 3; x.rtE = 4;
        vecs[12] = '{"fwdE_mixed", x, exp_o(0,0,0,0,0,0,0,0,2'd2,2'd1,0,0)};

        // ---------------- reset ----------------
        rst = 1'b1;
        apply(z);
        @(posedge clk);
        #1;
        settle();
        chk("rst_hold", dut_out(), 14'd0);
        $display("reset held out=%b", dut_out());
        advance();
        rst = 1'b0;
        settle();
        chk("post_rst", dut_out(), 14'd0);
        $display("reset released out=%b", dut_out());
        advance();

        // ---------------- table vectors ----------------
        for (int v = 0; v < 13; v++) begin
            apply(vecs[v].i);
            settle();
            chk(vecs[v].name, dut_out(), vecs[v].e);
            $display("vec %s out=%b", vecs[v].name, dut_out());
            advance();
        end

        // ---------------- load-use: one stall cycle then clear ----------------
        x = z; x.memtoregE = 1; x.regwriteE = 1; x.writeregE = 9; x.rtD = 9;
        apply(x); settle();
        chk("lu_c0", dut_out(), exp_o(1,1,0,0,1,0,0,0,2'd0,2'd0,0,0));
        $display("loaduse c0 out=%b", dut_out());
        advance();
        x = z; x.memtoregM = 1; x.regwriteM = 1; x.writeregM = 9; x.rtD = 9;
        apply(x); settle();
        chk("lu_c1", dut_out(), exp_o(0,0,0,0,0,0,0,1,2'd0,2'd0,0,0));
        $display("loaduse c1 out=%b", dut_out());
        advance();

        // ---------------- branch behind load, then forward ----------------
        x = z; x.branchD = 1; x.rsD = 5; x.memtoregM = 1; x.regwriteM = 1; x.writeregM = 5;
        apply(x); settle();
        chk("br_c0", dut_out(), exp_o(1,1,0,0,1,0,1,0,2'd0,2'd0,0,0));
        $display("branch c0 out=%b", dut_out());
        advance();
        x = z; x.branchD = 1; x.rsD = 5; x.regwriteM = 1; x.writeregM = 5;
        apply(x); settle();
        chk("br_c1", dut_out(), exp_o(0,0,0,0,0,0,1,0,2'd0,2'd0,0,0));
        $display("branch c1 out=%b", dut_out());
        advance();

        // ---------------- full divide ----------------
        n_start = 0; n_busy = 0; n_stallE = 0;
        for (int k = 0; k <= N + 1; k++) begin
            x = z;
            x.divE       = (k <= N);
            x.pred_missE = (k == 5);
            apply(x); settle();
            if (k == 0)      e = exp_o(1,1,1,0,0,0,0,0,2'd0,2'd0,1,0);
            else if (k < N)  e = exp_o(1,1,1,0,0,1,0,0,2'd0,2'd0,0,1);
            else             e = 14'd0;
            chk($sformatf("div_k%0d", k), dut_out(), e);
            $display("div k=%0d out=%b", k, dut_out());
            n_start  += int'(hif.div_start);
            n_busy   += int'(hif.div_busy);
            n_stallE += int'(hif.stallE);
            advance();
        end
        chk_int("div_start_pulses", n_start, 1);
        chk_int("div_busy_cycles", n_busy, N - 1);
        chk_int("div_stallE_cycles", n_stallE, N);

        // ---------------- reset in the middle of a divide ----------------
        for (int k = 0; k <= 10; k++) begin
            x = z; x.divE = 1'b1;
            apply(x);
            if (k == 10) rst = 1'b1;
            settle();
            if (k == 10) begin
                chk("rstdiv_hold", dut_out(), 14'd0);
                $display("rst mid-divide out=%b", dut_out());
            end
            advance();
        end
        rst = 1'b0;
        for (int k = 0; k < 3; k++) begin
            apply(z); settle();
            chk($sformatf("rstdiv_after%0d", k), dut_out(), 14'd0);
            $display("after rst k=%0d out=%b", k, dut_out());
            advance();
        end

        // ---------------- randomized against the model ----------------
        for (int c = 0; c < 2000; c++) begin
            rst = ($urandom_range(0, 149) == 0);
            apply(rand_in());
            settle();
            e = model(cur, age, rst);
            chk($sformatf("rand_c%0d", c), dut_out(), e);
            $display("rand c=%0d rst=%0b out=%b", c, rst, dut_out());
            advance();
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/hazard_ctrl.md
Name: hazard_ctrl

Overview:
- Central hazard and sequencing controller for the 5-stage MIPS pipeline.
- Drives stall/flush of the IF/ID, ID/EX and EX/MEM pipeline registers and the forwarding muxes in the ID and EX stages.
- Sequences the multi-cycle divider: holds F/D/E and bubbles M until the divide completes.
- Resolves load-use hazards, branch-operand hazards and E-stage mispredict flushes.

Parameters:
- DIV_CYCLES, 32, number of cycles the divider needs after div_start (legal range 2..64).
- CW, 6, counter width; must satisfy 2^CW > DIV_CYCLES.

Ports:
- clk  in  1  clock
- rst  in  1  synchronous reset, active-high
- rsD  in  5  source reg rs of D instr
- rtD  in  5  source reg rt of D instr
- branchD  in  1  D instr is a branch that compares operands in D
- rsE  in  5  rs of E instr
- rtE  in  5  rt of E instr
- writeregE  in  5  destination reg of E instr
- regwriteE  in  1  E instr writes GPR
- memtoregE  in  2  non-zero = E instr is a load
- divE  in  1  E instr is div/divu
- pred_missE  in  1  E-stage branch/jump mispredict
- writeregM  in  5  destination reg of M instr
- regwriteM  in  1  M instr writes GPR
- memtoregM  in  2  non-zero = M instr is a load
- writeregW  in  5  destination reg of W instr
- regwriteW  in  1  W instr writes GPR
- stallF  out  1  hold PC
- stallD  out  1  hold IF/ID
- stallE  out  1  hold ID/EX
- flushD  out  1  clear IF/ID
- flushE  out  1  clear ID/EX
- flushM  out  1  clear EX/MEM
- forwardaD  out  1  D operand a taken from M ALU result
- forwardbD  out  1  D operand b taken from M ALU result
- forwardaE  out  2  E operand a select: 00 reg file, 01 W result, 10 M result
- forwardbE  out  2  E operand b select: 00 reg file, 01 W result, 10 M result
- div_start  out  1  one-cycle divider launch pulse
- div_busy  out  1  divider sequence active (BUSY state)

Behaviour:
- Register 0 never matches any hazard or forwarding comparison.
- Forwarding (combinational):
  - forwardaE = 10 if regwriteM and writeregM==rsE.
  - Else forwardaE = 01 if regwriteW and writeregW==rsE.
  - Else forwardaE = 00. forwardbE follows the same rule using rtE.
  - forwardaD = regwriteM and writeregM==rsD. forwardbD uses rtD.
- lwstall = (memtoregE!=0) and (writeregE==rsD or writeregE==rtD).
- brstall = branchD and one of:
  - regwriteE and writeregE matches rsD or rtD;
  - (memtoregM!=0) and writeregM matches rsD or rtD.
- Divider FSM states: IDLE, BUSY, DONE. Counter cnt is CW bits wide.
  - IDLE:
    - If divE=1: div_start=1 and stallF=stallD=stallE=1 this cycle.
    - On the clock edge: next state BUSY, cnt<=DIV_CYCLES-2.
  - BUSY:
    - div_busy=1, stallF=stallD=stallE=1, flushM=1.
    - cnt decrements each cycle. When cnt==0, next state DONE.
  - DONE:
    - No divider stall. The E instr advances at the end of this cycle.
    - divE is ignored in this state (it is still the same instr).
    - Next state is always IDLE.
  - Total stall is DIV_CYCLES cycles, counting the start cycle.
- Output priority, highest first:
  1. FSM stall (IDLE with divE=1, or BUSY): the outputs listed in the FSM states above. flushD=flushE=0. lwstall, brstall and pred_missE are ignored.
  2. pred_missE: flushD=1, flushE=1, all stalls 0. This overrides lwstall/brstall, because the D instr is on the wrong path.
  3. lwstall or brstall: stallF=stallD=1, flushE=1, stallE=0.
  4. Otherwise every stall/flush output is 0.
- Reset:
  - FSM goes to IDLE, cnt=0.
  - The cycle after rst=1, all outputs are 0 given idle inputs.
  - During rst=1, stall/flush/div outputs are forced to 0.
  - A reset in the middle of a divide abandons the sequence; no div_start is reissued.
- No combinational path from div_busy to div_start. div_start never asserts in two consecutive cycles.

Test Plan:
- Forwarding:
  - regwriteM=1, writeregM=8, rsE=8; regwriteW=1, writeregW=8 -> forwardaE=10.
  - Drop regwriteM -> forwardaE=01.
  - writeregM=0, rsE=0 -> forwardaE=00.
- Load-use: memtoregE=01, writeregE=9, rtD=9 -> stallF=stallD=flushE=1 for exactly 1 cycle, then all 0 once the load reaches M.
- Branch hazard: branchD=1, rsD=5, memtoregM=01, writeregM=5 -> stallF=stallD=flushE=1.
  - Next cycle with regwriteM=1, writeregM=5 and no load -> forwardaD=1, no stall.
- Mispredict together with lwstall: pred_missE=1 and lwstall true -> flushD=flushE=1, stallF=stallD=0.
- Divide with DIV_CYCLES=32: divE=1 -> div_start pulses 1 cycle, then div_busy high for 31 cycles.
  - stallE high for 32 cycles total, then DONE for 1 cycle with no stall, then IDLE.
  - pred_missE asserted during BUSY -> no flushD.
- Reset mid-divide: rst at cycle 10 of BUSY -> next cycle state IDLE, div_busy=0, all stalls 0, div_start=0.
